// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB
//           operand forwarding, and load-use bubble insertion for a 5-stage MIPS.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc4,
    input  logic [WIDTH-1:0] in_rd1,
    input  logic [WIDTH-1:0] in_rd2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RADDR-1:0] in_rs,
    input  logic [RADDR-1:0] in_rt,
    input  logic [RADDR-1:0] in_rd,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic             in_alusrc,
    input  logic             in_regdst,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic             in_memtoreg,
    input  logic             in_branch,
    input  logic             exmem_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic             ex_valid,
    output logic [RADDR-1:0] ex_write_reg,
    output logic [WIDTH-1:0] ex_store_data,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic [WIDTH-1:0] ex_branch_target,
    output logic [WIDTH-1:0] ex_pc4,
    output logic             load_use_hazard,
    output logic             illegal_op
);

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_BAD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] pc4;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] imm;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] rd;
        logic [1:0]       aluop;
        logic [5:0]       funct;
        logic             alusrc;
        logic             regdst;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             branch;
    } id_ex_t;

    id_ex_t           entry_d;
    id_ex_t           entry_q;
    logic [RADDR-1:0] write_reg;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic             bad_op;

    assign write_reg = entry_q.regdst ? entry_q.rd : entry_q.rt;

    assign load_use_hazard = entry_q.valid & entry_q.memread & (write_reg != '0) & in_valid
                           & ((write_reg == in_rs) | (write_reg == in_rt));

    // A load-use bubble overrides stall so the dependent instruction is not lost twice.
    always_comb begin
        entry_d = entry_q;
        if (flush || load_use_hazard) begin
            entry_d = '0;
        end else if (!stall) begin
            entry_d.valid    = in_valid;
            entry_d.pc4      = in_pc4;
            entry_d.rd1      = in_rd1;
            entry_d.rd2      = in_rd2;
            entry_d.imm      = in_imm;
            entry_d.rs       = in_rs;
            entry_d.rt       = in_rt;
            entry_d.rd       = in_rd;
            entry_d.aluop    = in_aluop;
            entry_d.funct    = in_funct;
            entry_d.alusrc   = in_alusrc;
            entry_d.regdst   = in_regdst;
            entry_d.regwrite = in_regwrite;
            entry_d.memread  = in_memread;
            entry_d.memwrite = in_memwrite;
            entry_d.memtoreg = in_memtoreg;
            entry_d.branch   = in_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        alu_control = ALU_BAD;
        bad_op      = 1'b0;
        case (entry_q.aluop)
            ALUOP_MEM: alu_control = ALU_ADD;
            ALUOP_BEQ: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (entry_q.funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   bad_op      = 1'b1;
                endcase
            end
            default: bad_op = 1'b1;
        endcase
    end

    // EX/MEM is the younger producer, so it is checked first; r0 is never forwarded.
    always_comb begin
        fwd_a = entry_q.rd1;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == entry_q.rs)) begin
            fwd_a = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == entry_q.rs)) begin
            fwd_a = memwb_result;
        end
    end

    always_comb begin
        fwd_b = entry_q.rd2;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == entry_q.rt)) begin
            fwd_b = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == entry_q.rt)) begin
            fwd_b = memwb_result;
        end
    end

    assign alu_a            = fwd_a;
    assign alu_b            = entry_q.alusrc ? entry_q.imm : fwd_b;
    assign ex_store_data    = fwd_b;
    assign illegal_op       = bad_op & entry_q.valid;
    assign ex_valid         = entry_q.valid;
    assign ex_write_reg     = write_reg;
    assign ex_regwrite      = entry_q.regwrite & entry_q.valid;
    assign ex_memread       = entry_q.memread  & entry_q.valid;
    assign ex_memwrite      = entry_q.memwrite & entry_q.valid;
    assign ex_memtoreg      = entry_q.memtoreg & entry_q.valid;
    assign ex_branch        = entry_q.branch   & entry_q.valid;
    assign ex_branch_target = entry_q.pc4 + {entry_q.imm[WIDTH-3:0], 2'b00};
    assign ex_pc4           = entry_q.pc4;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Purpose : Self-checking bench for id_ex_stage: vector table, directed corner
//           sequences and randomized traffic against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc;
        logic        regdst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        branch;
    } in_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt;
        logic        alusrc;
        logic        exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        mwb_we;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_res;
        logic [31:0] exp_a, exp_b;
        logic [2:0]  exp_ctl;
        logic        exp_ill;
        logic [31:0] exp_tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    in_t         drv = '0;
    logic        exmem_regwrite = 1'b0;
    logic [4:0]  exmem_rd = '0;
    logic [31:0] exmem_result = '0;
    logic        memwb_regwrite = 1'b0;
    logic [4:0]  memwb_rd = '0;
    logic [31:0] memwb_result = '0;

    logic [31:0] alu_a, alu_b, ex_store_data, ex_branch_target, ex_pc4;
    logic [2:0]  alu_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
    logic        load_use_hazard, illegal_op;

    int checks = 0;
    int errors = 0;
    in_t m;  // model of the instruction currently held in EX

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(drv.valid), .in_pc4(drv.pc4), .in_rd1(drv.rd1), .in_rd2(drv.rd2),
        .in_imm(drv.imm), .in_rs(drv.rs), .in_rt(drv.rt), .in_rd(drv.rd),
        .in_aluop(drv.aluop), .in_funct(drv.funct), .in_alusrc(drv.alusrc),
        .in_regdst(drv.regdst), .in_regwrite(drv.regwrite), .in_memread(drv.memread),
        .in_memwrite(drv.memwrite), .in_memtoreg(drv.memtoreg), .in_branch(drv.branch),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_valid(ex_valid),
        .ex_write_reg(ex_write_reg), .ex_store_data(ex_store_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_branch_target(ex_branch_target), .ex_pc4(ex_pc4),
        .load_use_hazard(load_use_hazard), .illegal_op(illegal_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_ctl(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'd0) return 3'd2;
        if (aluop == 2'd1) return 3'd6;
        if (aluop == 2'd2) begin
            case (funct)
                6'd32:   return 3'd2;
                6'd34:   return 3'd6;
                6'd36:   return 3'd0;
                6'd37:   return 3'd1;
                6'd42:   return 3'd7;
                default: return 3'd3;
            endcase
        end
        return 3'd3;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regval);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return memwb_result;
        return regval;
    endfunction

    function automatic logic ref_hazard();
        logic [4:0] wr;
        wr = m.regdst ? m.rd : m.rt;
        return m.valid && m.memread && wr != 0 && drv.valid && (wr == drv.rs || wr == drv.rt);
    endfunction

    task automatic check_model();
        logic [2:0] ctl;
        ctl = ref_ctl(m.aluop, m.funct);
        chk("rnd_valid", ex_valid, m.valid);
        chk("rnd_alu_a", alu_a, ref_fwd(m.rs, m.rd1));
        chk("rnd_alu_b", alu_b, m.alusrc ? m.imm : ref_fwd(m.rt, m.rd2));
        chk("rnd_store", ex_store_data, ref_fwd(m.rt, m.rd2));
        chk("rnd_ctl", alu_control, ctl);
        chk("rnd_illegal", illegal_op, m.valid && ctl == 3'd3);
        chk("rnd_wreg", ex_write_reg, m.regdst ? m.rd : m.rt);
        chk("rnd_ctrls", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch},
            m.valid ? {m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch} : 5'd0);
        chk("rnd_target", ex_branch_target, m.pc4 + m.imm * 4);
        chk("rnd_pc4", ex_pc4, m.pc4);
    endtask

    // One clock with the currently driven inputs; model advances alongside the DUT.
    task automatic cycle();
        logic hz;
        #1;
        hz = ref_hazard();
        chk("rnd_hazard", load_use_hazard, hz);
        if (flush || hz) m = '0;
        else if (!stall) m = drv;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                           input logic mw, input logic [4:0] mr, input logic [31:0] mv);
        exmem_regwrite = ew; exmem_rd = er; exmem_result = ev;
        memwb_regwrite = mw; memwb_rd = mr; memwb_result = mv;
    endtask

    vec_t vecs[12];

    initial begin
        m = '0;
        // ----- reset state -----
        #3;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctl", alu_control, 3'b010);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_regwrite", ex_regwrite, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ----- vector table -----
        //          aluop  funct   rd1    rd2   imm           pc4          rs rt src  exm             mwb              a      b      ctl   ill tgt
        vecs[0]  = '{2'b10, 6'h20, 32'd5, 32'd7, 32'd0,       32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd5, 32'd7, 3'b010, 0, 32'd0};
        vecs[1]  = '{2'b10, 6'h22, 32'd10, 32'd3, 32'd0,      32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd10, 32'd3, 3'b110, 0, 32'd0};
        vecs[2]  = '{2'b10, 6'h24, 32'd1, 32'd2, 32'd0,       32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd1, 32'd2, 3'b000, 0, 32'd0};
        vecs[3]  = '{2'b10, 6'h25, 32'd1, 32'd2, 32'd0,       32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd1, 32'd2, 3'b001, 0, 32'd0};
        vecs[4]  = '{2'b10, 6'h2A, 32'd1, 32'd2, 32'd0,       32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd1, 32'd2, 3'b111, 0, 32'd0};
        vecs[5]  = '{2'b10, 6'h20, 32'd9, 32'd4, 32'd0,       32'd0,       3, 2, 0, 1, 3, 32'hAA,  1, 3, 32'hBB,  32'hAA, 32'd4, 3'b010, 0, 32'd0};
        vecs[6]  = '{2'b10, 6'h20, 32'd9, 32'd4, 32'd0,       32'd0,       3, 2, 0, 1, 0, 32'hAA,  1, 0, 32'hBB,  32'd9, 32'd4, 3'b010, 0, 32'd0};
        vecs[7]  = '{2'b10, 6'h20, 32'd9, 32'd4, 32'd0,       32'd0,       3, 4, 0, 1, 3, 32'hAA,  1, 4, 32'h55,  32'hAA, 32'h55, 3'b010, 0, 32'd0};
        vecs[8]  = '{2'b01, 6'h00, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h10,     1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd1, 32'd1, 3'b110, 0, 32'hC};
        vecs[9]  = '{2'b01, 6'h00, 32'd1, 32'd1, 32'd1,       32'hFFFFFFFC, 1, 2, 0, 0, 0, 0,      0, 0, 0,       32'd1, 32'd1, 3'b110, 0, 32'd0};
        vecs[10] = '{2'b00, 6'h00, 32'd8, 32'd6, 32'h20,      32'd0,       1, 2, 1, 0, 0, 0,       0, 0, 0,       32'd8, 32'h20, 3'b010, 0, 32'h80};
        vecs[11] = '{2'b10, 6'h00, 32'd8, 32'd6, 32'd0,       32'd0,       1, 2, 0, 0, 0, 0,       0, 0, 0,       32'd8, 32'd6, 3'b011, 1, 32'd0};

        for (int i = 0; i < 12; i++) begin
            drv = '0;
            drv.valid = 1'b1; drv.regdst = 1'b1; drv.rd = 5'd5; drv.regwrite = 1'b1;
            drv.aluop = vecs[i].aluop; drv.funct = vecs[i].funct;
            drv.rd1 = vecs[i].rd1; drv.rd2 = vecs[i].rd2; drv.imm = vecs[i].imm;
            drv.pc4 = vecs[i].pc4; drv.rs = vecs[i].rs; drv.rt = vecs[i].rt;
            drv.alusrc = vecs[i].alusrc;
            drv.branch = (vecs[i].aluop == 2'b01);
            set_fwd(vecs[i].exm_we, vecs[i].exm_rd, vecs[i].exm_res,
                    vecs[i].mwb_we, vecs[i].mwb_rd, vecs[i].mwb_res);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), alu_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_ctl", i), alu_control, vecs[i].exp_ctl);
            chk($sformatf("vec%0d_ill", i), illegal_op, vecs[i].exp_ill);
            chk($sformatf("vec%0d_tgt", i), ex_branch_target, vecs[i].exp_tgt);
            chk($sformatf("vec%0d_valid", i), ex_valid, 1);
            chk($sformatf("vec%0d_branch", i), ex_branch, vecs[i].aluop == 2'b01);
        end
        set_fwd(0, 0, 0, 0, 0, 0);

        // ----- load-use hazard, including with stall high -----
        for (int s = 0; s < 2; s++) begin
            drv = '0;
            drv.valid = 1; drv.rs = 1; drv.rt = 8; drv.memread = 1; drv.regwrite = 1;
            drv.memtoreg = 1; drv.aluop = 2'b00; drv.alusrc = 1;
            @(posedge clk); #1;
            chk("lw_valid", ex_valid, 1);
            chk("lw_wreg", ex_write_reg, 8);
            drv = '0;
            drv.valid = 1; drv.rs = 8; drv.rt = 2; drv.regwrite = 1; drv.aluop = 2'b10; drv.funct = 6'h20;
            stall = (s == 1);
            #1;
            chk("lu_hazard", load_use_hazard, 1);
            @(posedge clk); #1;
            chk("lu_bubble_valid", ex_valid, 0);
            chk("lu_bubble_regwrite", ex_regwrite, 0);
            chk("lu_hazard_drop", load_use_hazard, 0);
            stall = 0;
        end

        // ----- stall hold for three edges, then flush with stall -----
        drv = '0;
        drv.valid = 1; drv.rd1 = 32'h11; drv.rd2 = 32'h22; drv.rs = 1; drv.rt = 2;
        drv.aluop = 2'b10; drv.funct = 6'h20; drv.regwrite = 1;
        @(posedge clk); #1;
        chk("st_load_a", alu_a, 32'h11);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            drv.rd1 = $urandom; drv.rd2 = $urandom; drv.funct = 6'h22; drv.rs = 5'd3;
            @(posedge clk); #1;
            chk("st_hold_a", alu_a, 32'h11);
            chk("st_hold_b", alu_b, 32'h22);
            chk("st_hold_ctl", alu_control, 3'b010);
            chk("st_hold_valid", ex_valid, 1);
        end
        flush = 1;
        @(posedge clk); #1;
        chk("flush_valid", ex_valid, 0);
        chk("flush_regwrite", ex_regwrite, 0);
        flush = 0; stall = 0;

        // ----- illegal op then asynchronous reset mid-cycle -----
        drv = '0;
        drv.valid = 1; drv.aluop = 2'b10; drv.funct = 6'h00; drv.rd1 = 32'h33;
        @(posedge clk); #1;
        chk("ill_ctl", alu_control, 3'b011);
        chk("ill_flag", illegal_op, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_illegal", illegal_op, 0);
        chk("arst_a", alu_a, 0);
        @(posedge clk); #1 rst_n = 1;

        // ----- asynchronous reset while a hazard is pending -----
        drv = '0;
        drv.valid = 1; drv.rt = 6; drv.memread = 1;
        @(posedge clk); #1;
        drv = '0; drv.valid = 1; drv.rt = 6;
        #1;
        chk("arst_hz_before", load_use_hazard, 1);
        rst_n = 0;
        #1;
        chk("arst_hz_after", load_use_hazard, 0);
        @(posedge clk); #1 rst_n = 1;
        m = '0;

        // ----- randomized traffic against the model -----
        for (int n = 0; n < 400; n++) begin
            logic [5:0] fl[5];
            int fi;
            fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            drv.valid    = ($urandom_range(9) != 0);
            drv.pc4      = $urandom;
            drv.rd1      = $urandom;
            drv.rd2      = $urandom;
            drv.imm      = $urandom;
            drv.rs       = 5'($urandom_range(3));
            drv.rt       = 5'($urandom_range(3));
            drv.rd       = 5'($urandom_range(3));
            drv.aluop    = 2'($urandom_range(3));
            fi           = $urandom_range(5);
            drv.funct    = (fi < 5) ? fl[fi] : 6'($urandom);
            drv.alusrc   = 1'($urandom);
            drv.regdst   = 1'($urandom);
            drv.regwrite = 1'($urandom);
            drv.memread  = ($urandom_range(2) == 0);
            drv.memwrite = 1'($urandom);
            drv.memtoreg = 1'($urandom);
            drv.branch   = 1'($urandom);
            stall        = ($urandom_range(6) == 0);
            flush        = ($urandom_range(9) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(3)), $urandom,
                    1'($urandom), 5'($urandom_range(3)), $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-stage front end for the 5-stage MIPS datapath.
- Captures decoded instruction fields and derives the 3-bit ALU control code from ALUOp/funct.
- Applies EX/MEM and MEM/WB operand forwarding and drives the ALU a/b/control inputs directly.
- Detects load-use hazards and inserts bubbles itself. Passes memory/writeback controls and the branch target downstream.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all ID/EX contents.
- flush  in  1  replace the next ID/EX entry with a bubble.
- in_valid  in  1  decode stage holds a real instruction.
- in_pc4  in  WIDTH  PC+4 of the decoding instruction.
- in_rd1, in_rd2  in  WIDTH  register-file read data for rs and rt.
- in_imm  in  WIDTH  sign-extended immediate.
- in_rs, in_rt, in_rd  in  RADDR  register specifiers.
- in_aluop  in  2  00 = lw/sw add, 01 = beq sub, 10 = R-type (use funct), 11 = reserved.
- in_funct  in  6  R-type funct field.
- in_alusrc, in_regdst, in_regwrite, in_memread, in_memwrite, in_memtoreg, in_branch  in  1 each  decoded controls.
- exmem_regwrite  in  1  EX/MEM forwarding source: write enable.
- exmem_rd  in  RADDR  EX/MEM forwarding source: destination register.
- exmem_result  in  WIDTH  EX/MEM forwarding source: result.
- memwb_regwrite  in  1  MEM/WB forwarding source: write enable.
- memwb_rd  in  RADDR  MEM/WB forwarding source: destination register.
- memwb_result  in  WIDTH  MEM/WB forwarding source: result.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_control  out  3  ALU operation code.
- ex_valid  out  1  EX holds a real instruction.
- ex_write_reg  out  RADDR  destination register.
- ex_store_data  out  WIDTH  forwarded rt value for sw.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1 each  controls, gated by ex_valid.
- ex_branch_target  out  WIDTH  branch target address.
- ex_pc4  out  WIDTH  registered PC+4.
- load_use_hazard  out  1  upstream must hold IF/ID this cycle.
- illegal_op  out  1  unsupported ALUOp/funct in a valid EX entry.

Behaviour:
- Reset (rst_n low, asynchronous): every ID/EX register clears to 0, so ex_valid = 0 and all gated controls = 0. With aluop = 00 after reset, alu_control = 010; alu_a = alu_b = 0; illegal_op = 0.
- Edge priority: flush > load_use_hazard > stall > normal load.
  - flush or hazard: load a bubble (all fields 0, valid 0).
  - stall only: hold all contents.
  - Otherwise: capture all in_* fields, with valid = in_valid.
- Latency: one cycle from in_* capture to outputs. Every output is combinational from registered state plus the forwarding inputs.
- load_use_hazard = ex_valid & ex_memread & (ex_write_reg != 0) & in_valid & (ex_write_reg == in_rs | ex_write_reg == in_rt). This is combinational. The bubble it causes applies even when stall is high.
- ex_write_reg = regdst ? rd : rt.
- ALU control:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct, or aluop 11 -> 011, and illegal_op = ex_valid.
- Forwarding, rs operand (fwdA):
  - If exmem_regwrite & exmem_rd != 0 & exmem_rd == rs -> exmem_result.
  - Else if memwb_regwrite & memwb_rd != 0 & memwb_rd == rs -> memwb_result.
  - Else the registered rd1.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Forwarding, rt operand (fwdB): identical to fwdA, using rt and rd2.
- Operand outputs: alu_a = fwdA; alu_b = alusrc ? imm : fwdB; ex_store_data = fwdB, always, independent of alusrc.
- ex_branch_target = pc4 + (imm << 2), truncated mod 2^WIDTH with no overflow flag. It is computed from registered values.
- Gated controls: ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg and ex_branch equal their registered value AND ex_valid.
- Reset asserted mid-stall or mid-hazard clears state immediately. load_use_hazard then drops in the same cycle.

Test Plan:
- Reset, then load add (aluop 10, funct 100000, rd1 = 5, rd2 = 7, no forwarding match) -> next cycle alu_a = 5, alu_b = 7, alu_control = 010, ex_valid = 1, illegal_op = 0.
- EX holds rs = 3; exmem_rd = 3 with result 0xAA and memwb_rd = 3 with result 0xBB, both regwrite = 1 -> alu_a = 0xAA. Same scenario with exmem_rd = 0 and memwb_rd = 0 -> alu_a = registered rd1.
- EX holds lw rt = 8 (memread = 1); decode holds in_rs = 8, in_valid = 1 -> load_use_hazard = 1. After the edge: ex_valid = 0, ex_regwrite = 0, load_use_hazard = 0.
- beq with pc4 = 0x0000_0010, imm = 0xFFFF_FFFF -> ex_branch_target = 0x0000_000C, alu_control = 110, ex_branch = 1. With pc4 = 0xFFFF_FFFC, imm = 1 -> ex_branch_target = 0x0000_0000.
- stall held for 3 edges with changing inputs -> outputs unchanged. Assert flush together with stall -> bubble on the next edge.
- aluop 10, funct 000000 -> alu_control = 011, illegal_op = 1. Then assert rst_n = 0 mid-cycle -> ex_valid = 0 and illegal_op = 0 without waiting for a clock edge.
